// File: rtl/direction_pkg.sv
// Shared types for the direction command path: direction codes, encoder FSM
// states and the push-button to direction mapping.
package direction_pkg;

  typedef enum logic [1:0] {
    DIR_FWD   = 2'b00,
    DIR_REV   = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_TAIL,
    ST_CONFLICT
  } state_t;

  localparam int NUM_KEYS = 4;

  // Key index -> direction, packed two bits per key with key 0 in the LSBs:
  // key 0 right, key 1 left, key 2 forward, key 3 reverse.
  localparam logic [2*NUM_KEYS-1:0] KEY_DIR_MAP = {DIR_REV, DIR_FWD, DIR_LEFT, DIR_RIGHT};

  function automatic dir_t key_dir(input logic [1:0] idx);
    return dir_t'(KEY_DIR_MAP[2*idx +: 2]);
  endfunction

  // Index of the lowest pressed key; only meaningful when exactly one is pressed.
  function automatic logic [1:0] first_key(input logic [NUM_KEYS-1:0] keys);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One push-button: 2-flop synchroniser with inversion to active-high, a
// consecutive-stable-cycle debounce counter and a one-cycle press pulse on
// each accepted release->press transition.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a new level only after it has held for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: every register here uses non-blocking assignment so all flops
    // sample the pre-edge values; blocking would collapse the synchroniser.
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], ~key_n};
      press <= 1'b0;
      if (sync[1] == level) begin
        // Any bounce back to the accepted level restarts the count.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        press <= sync[1];
        cnt   <= '0;
      end else begin
        // Stops at CNT_LAST, so the counter can never wrap.
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/direction_cmd_encoder.sv
// Turns four active-low push-buttons into a registered {enable, direc} command
// with a change strobe and a conflict flag.
// Optional build macro DIRECTION_LATCH_EN selects latch mode: a drive holds
// after release and a second press of the same key stops it (no tail).
module direction_cmd_encoder
  import direction_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_n,
  output logic       enable,
  output logic [1:0] direc,
  output logic       conflict,
  output logic       changed
);

  localparam int HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] press;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk  (clk),
      .reset(reset),
      .key_n(key_n[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  state_t        state_q, state_d;
  dir_t          dir_q, dir_d;
  logic          enable_d, conflict_d;
  logic [HW-1:0] hold_cnt;
  logic          hold_clr;

  logic          n_none, n_one, n_multi;
  logic [1:0]    key_idx;
  dir_t          key_code;
  logic          hold_expired;

  // Classify the stable key vector: none, exactly one, or several pressed.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    n_none   = (level == '0);
    n_one    = !n_none && ((level & (level - 1'b1)) == '0);
    n_multi  = !n_none && !n_one;
    key_idx  = first_key(level);
    key_code = key_dir(key_idx);
  end

  assign hold_expired = (hold_cnt == HOLD_LAST);

  // State register plus the direction it commands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_FWD;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  // Next state and next direction; direction only moves while driving.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    hold_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // IDLE is always entered with no keys down, so a single key appears
        // together with its press pulse; requiring the pulse also keeps a key
        // still held after a latch-mode stop from restarting the drive.
        if (n_multi) begin
          state_d = ST_CONFLICT;
        end else if (n_one && press[key_idx]) begin
          state_d = ST_DRIVE;
          dir_d   = key_code;
        end
      end
      ST_DRIVE: begin
`ifdef DIRECTION_LATCH_EN
        if (n_multi) begin
          state_d = ST_CONFLICT;
        end else if (n_one && press[key_idx]) begin
          if (key_code == dir_q) state_d = ST_IDLE;
          else                   dir_d   = key_code;
        end
`else
        if (n_multi) begin
          state_d = ST_CONFLICT;
        end else if (n_one) begin
          dir_d = key_code;
        end else begin
          state_d  = ST_TAIL;
          hold_clr = 1'b1;
        end
`endif
      end
      ST_TAIL: begin
        // A key arriving in the expiry cycle takes priority over the timeout.
        if (n_multi) begin
          state_d = ST_CONFLICT;
        end else if (n_one) begin
          state_d = ST_DRIVE;
          dir_d   = key_code;
        end else if (hold_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_CONFLICT: begin
        if (n_none) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so outputs register on the same edge.
  always_comb begin
    enable_d   = (state_d == ST_DRIVE) || (state_d == ST_TAIL);
    conflict_d = (state_d == ST_CONFLICT);
  end

  // Registered outputs; the strobe compares against the value being replaced.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable   <= 1'b0;
      conflict <= 1'b0;
      changed  <= 1'b0;
    end else begin
      enable   <= enable_d;
      conflict <= conflict_d;
      changed  <= ({enable_d, dir_d} != {enable, dir_q});
    end
  end

  assign direc = dir_q;

  // Hold timer: cleared on entry to TAIL, counts while in TAIL, saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (hold_clr) begin
      hold_cnt <= '0;
    end else if (state_q == ST_TAIL && hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_direction_cmd_encoder.sv
// Scoreboard bench for direction_cmd_encoder with DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=8. Each stimulus pushes the output change it should cause,
// with the cycle it must appear in; a negedge monitor pops and compares.
module tb_direction_cmd_encoder;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int LAT  = DEB + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic       enable;
  logic [1:0] direc;
  logic       conflict;
  logic       changed;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  // Expected output change: value {conflict, enable, direc} and its cycle.
  typedef struct {
    int         cyc;
    logic [3:0] val;
  } evt_t;

  evt_t       q[$];
  logic [3:0] cur;
  logic [3:0] prev = 4'h0;

  direction_cmd_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_n),
    .enable  (enable),
    .direc   (direc),
    .conflict(conflict),
    .changed (changed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] v);
    evt_t e;
    e.cyc = c;
    e.val = v;
    q.push_back(e);
  endtask

  // Drive keys just after a falling edge; returns the edge count at that point.
  task automatic set_keys(input logic [3:0] k, output int c);
    @(negedge clk);
    #1;
    key_n = k;
    c = cyc;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every output change must match the next expected event.
  always @(negedge clk) begin
    cur = {conflict, enable, direc};
    if (mon_en) begin
      if (q.size() > 0 && cyc > q[0].cyc) begin
        check("evt_missing", 32'(cyc), 32'(q[0].cyc));
        void'(q.pop_front());
      end
      if (cur != prev) begin
        if (q.size() == 0) begin
          check("evt_unexpected", 32'(cur), 32'(prev));
        end else begin
          evt_t e;
          e = q.pop_front();
          check("evt_val", 32'(cur), 32'(e.val));
          check("evt_cyc", 32'(cyc), 32'(e.cyc));
        end
        check("changed_strobe", 32'(changed), 32'(cur[2:0] != prev[2:0]));
      end else if (changed) begin
        check("changed_spurious", 32'(changed), 32'(1'b0));
      end
    end
    prev = cur;
  end

  initial begin
    int c, c2;

    // Reset state with keys released.
    wait_cycles(3);
    #1;
    check("rst_enable", 32'(enable), 32'(0));
    check("rst_direc", 32'(direc), 32'(0));
    check("rst_conflict", 32'(conflict), 32'(0));
    check("rst_changed", 32'(changed), 32'(0));
    @(negedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    wait_cycles(2);

`ifndef DIRECTION_LATCH_EN
    // Single clean press of key 2 (forward), then release and hold tail.
    set_keys(4'b1011, c);
    push(c + LAT, 4'b0_1_00);
    wait_cycles(10);
    set_keys(4'hF, c);
    push(c + LAT + HOLD, 4'b0_0_00);
    wait_cycles(20);
    check("q_empty_press", 32'(q.size()), 32'(0));

    // Bounce on key 0 every 2 cycles, then settle pressed (right).
    for (int i = 0; i < 10; i++) begin
      set_keys(key_n ^ 4'b0001, c);
      wait_cycles(1);
    end
    set_keys(4'b1110, c);
    push(c + LAT, 4'b0_1_11);
    wait_cycles(10);
    set_keys(4'hF, c);
    push(c + LAT + HOLD, 4'b0_0_11);
    wait_cycles(20);
    check("q_empty_bounce", 32'(q.size()), 32'(0));

    // Keys 1 and 3 together: conflict; partial release keeps it.
    set_keys(4'b0101, c);
    push(c + LAT, 4'b1_0_11);
    wait_cycles(10);
    set_keys(4'b1101, c);
    wait_cycles(12);
    set_keys(4'hF, c);
    push(c + LAT, 4'b0_0_11);
    wait_cycles(12);
    check("q_empty_conflict", 32'(q.size()), 32'(0));

    // Key 2 swapped for key 3 in one cycle: direction changes while driving.
    set_keys(4'b1011, c);
    push(c + LAT, 4'b0_1_00);
    wait_cycles(10);
    set_keys(4'b0111, c);
    push(c + LAT, 4'b0_1_01);
    wait_cycles(10);
    set_keys(4'hF, c);
    push(c + LAT + HOLD, 4'b0_0_01);
    wait_cycles(20);
    check("q_empty_swap", 32'(q.size()), 32'(0));

    // Key 3 then key 1 arriving exactly in the tail expiry cycle.
    set_keys(4'b0111, c);
    push(c + LAT, 4'b0_1_01);
    wait_cycles(10);
    set_keys(4'hF, c2);
    wait_cycles(7);
    set_keys(4'b1101, c);
    check("tail_timing", 32'(c + LAT), 32'(c2 + LAT + HOLD));
    push(c + LAT, 4'b0_1_10);
    wait_cycles(12);
    set_keys(4'hF, c);
    push(c + LAT + HOLD, 4'b0_0_10);
    wait_cycles(20);
    check("q_empty_tail", 32'(q.size()), 32'(0));

    // Asynchronous reset mid-drive with key 0 still held afterwards.
    set_keys(4'b1110, c);
    push(c + LAT, 4'b0_1_11);
    wait_cycles(10);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check("mid_rst_enable", 32'(enable), 32'(0));
    check("mid_rst_direc", 32'(direc), 32'(0));
    check("mid_rst_changed", 32'(changed), 32'(0));
    wait_cycles(3);
    @(negedge clk);
    #1;
    reset  = 1'b0;
    c      = cyc;
    mon_en = 1'b1;
    push(c + LAT, 4'b0_1_11);
    wait_cycles(10);
    set_keys(4'hF, c);
    push(c + LAT + HOLD, 4'b0_0_11);
    wait_cycles(20);
    check("q_empty_reset", 32'(q.size()), 32'(0));
`else
    // Latch mode: key 0 starts a drive that survives release; pressing it again stops.
    set_keys(4'b1110, c);
    push(c + LAT, 4'b0_1_11);
    wait_cycles(10);
    set_keys(4'hF, c);
    wait_cycles(30);
    check("latch_hold_enable", 32'(enable), 32'(1));
    set_keys(4'b1110, c);
    push(c + LAT, 4'b0_0_11);
    wait_cycles(10);
    set_keys(4'hF, c);
    wait_cycles(20);
    check("q_empty_latch", 32'(q.size()), 32'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/direction_cmd_encoder.md
# direction_cmd_encoder

Command-side counterpart of the direction display. It turns the four board push-buttons into the 2-bit direction code plus enable that the display and motor logic consume. Raw active-low key inputs are synchronised, debounced and rejected when they conflict, then run through a drive/hold state machine. The result is a clean, registered `{enable, direc}` pair with a change strobe.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); minimum 1.
- `HOLD_CYCLES`, default 5000000: cycles that `enable` stays high after the last key release (100 ms); minimum 1.

Ports:
- `clk`  in  1: single clock; every register is on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `key_n`  in  4: raw push-buttons, active-low, asynchronous. Bit 0 = right, 1 = left, 2 = forward, 3 = reverse.
- `enable`  out  1: a direction is being commanded.
- `direc`  out  2: direction code. 00 forward, 01 reverse, 10 left, 11 right.
- `conflict`  out  1: more than one key is pressed, so the command is rejected.
- `changed`  out  1: one-cycle strobe on any change of `{enable, direc}`.

## Operation
- **Key input path.** Each key passes through a 2-flop synchroniser and is inverted to active-high. The debouncer then changes its stable level only after the synchronised input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count. The debouncer emits `press` for one cycle on each accepted 0->1 transition.
- **Key count.** `n` is the number of stable pressed keys.
- **IDLE:** `enable`=0.
  - `n`==1: go to DRIVE, with `direc` set to that key's code.
  - `n`>=2: go to CONFLICT.
- **DRIVE:** `enable`=1.
  - `n`>=2: go to CONFLICT.
  - `n`==1 and the key differs from `direc`: update `direc` and stay in DRIVE.
  - `n`==0: go to TAIL and clear the hold counter.
- **TAIL:** `enable`=1. The hold counter increments each cycle.
  - When the counter reaches `HOLD_CYCLES`-1: go to IDLE.
  - `n`==1: go to DRIVE with that key's code; the counter is discarded.
  - `n`>=2: go to CONFLICT.
- **CONFLICT:** `enable`=0, `conflict`=1. Go to IDLE only when `n`==0. Partial releases (`n`==1) do not start a drive.
- **`direc` when not enabled.** `direc` holds its last value whenever `enable`=0.
- **`changed`.** `changed`=1 exactly in the first cycle in which the registered `{enable, direc}` differs from its value in the previous cycle.
- **Simultaneous events.**
  - If two keys become stable in the same cycle, `n` jumps 0->2, which means CONFLICT, never DRIVE.
  - In TAIL, a press that arrives in the expiry cycle wins: the state goes to DRIVE.
- **Reset mid-operation.** All debouncer counters are cleared, stable levels go to released, and the state goes to IDLE. A key still held when reset is released is accepted after a full debounce period.

## Timing
- Reset values:
  - `enable`=0, `direc`=00, `conflict`=0, `changed`=0.
  - State IDLE, all counters 0.
- Latency, key_n falling edge (clean) to `enable`=1: exactly `DEBOUNCE_CYCLES`+3 rising edges.
  - 2 edges in the synchroniser.
  - `DEBOUNCE_CYCLES` edges in the debouncer.
  - 1 edge in the FSM output register.
- Release to `enable`=0 in non-latch mode: `DEBOUNCE_CYCLES`+3+`HOLD_CYCLES` edges.
- `changed` asserts in the same cycle the new `{enable, direc}` first appears, since it is registered alongside them.
- All outputs are registered, with no combinational path from `key_n`.
- Counter widths:
  - Debounce counter: `$clog2(DEBOUNCE_CYCLES+1)`.
  - Hold counter: `$clog2(HOLD_CYCLES+1)`.
  - Counters saturate and never wrap.

## Configuration
- `DIRECTION_LATCH_EN` defined: latch mode. TAIL is unused. In DRIVE:
  - `n`==0 keeps DRIVE and holds `enable`=1.
  - A `press` of the key matching `direc` goes to IDLE (stop).
  - A `press` of another key while `n`==1 changes `direc`.
  - `n`>=2 still goes to CONFLICT.
- Undefined: hold-plus-tail behaviour exactly as in Operation.

## Structure
- Package `direction_pkg` holds:
  - `typedef enum logic [1:0] dir_t`: `DIR_FWD`=00, `DIR_REV`=01, `DIR_LEFT`=10, `DIR_RIGHT`=11.
  - The FSM state enum: `ST_IDLE`, `ST_DRIVE`, `ST_TAIL`, `ST_CONFLICT`.
  - The key index to `dir_t` mapping constant.
- The display module imports the same `dir_t`.
- Sub-module `key_debouncer`: synchroniser, debounce counter and `press` pulse for one key, parameterised by `DEBOUNCE_CYCLES`. It is instantiated 4 times.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `HOLD_CYCLES`=8.
- **Reset state.** Reset asserted with keys released -> all outputs 0. Assert reset mid-DRIVE -> `enable`=0 at once (asynchronous); after reset is released with the key still held, `enable`=1 again 7 edges later.
- **Single clean press.** Press key 2 cleanly -> at edge 7 `enable`=1, `direc`=00, `changed`=1 for one cycle. Release -> `enable` stays 1 for 8 more cycles after debounce, then drops with `changed`=1.
- **Bounce rejection.** key_n[0] toggles every 2 cycles for 20 cycles, then settles low -> no output change until 7 edges after settling, then `direc`=11.
- **Conflict.** Press keys 1 and 3 in the same cycle -> `conflict`=1 and `enable`=0. Release key 3 -> still in CONFLICT. Release key 1 -> IDLE and `conflict`=0.
- **Direction change in TAIL.** Key 3 pressed then released; key 1 pressed during the tail -> `enable` never drops, `direc` 01->10, one `changed` strobe.
- **Latch mode (`DIRECTION_LATCH_EN`).** Press and release key 0 -> `enable` stays 1 indefinitely. Press key 0 again -> `enable`=0 at debounce + 3 edges.
